// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES decryption arbiter.
//   arb_state_t  : arbiter FSM states
//   WDOG_W       : width of the RUN-state watchdog counter
//   port_onehot  : maps a 1-bit port index to its one-hot 2-bit mask
package aes_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      RESP
   } arb_state_t;

   localparam int unsigned WDOG_W = 8;

   function automatic logic [1:0] port_onehot(logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/aes_arbiter_if.sv
// Bundle of request, response and core-side signals for aes_arbiter.
//   req_*  : two requesting ports (valid/ready accept, per-port key and ciphertext)
//   rsp_*  : per-port result handshake (valid held until ack), shared data/err
//   core_* : connection to the external AES decryption core
// Modports: slave = arbiter side, master = client/core side.
interface aes_arbiter_if;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [127:0] req0_key;
   logic [127:0] req1_key;
   logic [127:0] req0_msg;
   logic [127:0] req1_msg;
   logic [1:0]   rsp_valid;
   logic [1:0]   rsp_ack;
   logic [127:0] rsp_data;
   logic         rsp_err;
   logic         core_start;
   logic [127:0] core_key;
   logic [127:0] core_msg;
   logic         core_done;
   logic [127:0] core_dec;

   modport slave (
      input  req_valid, req0_key, req1_key, req0_msg, req1_msg, rsp_ack, core_done, core_dec,
      output req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_key, core_msg
   );

   modport master (
      output req_valid, req0_key, req1_key, req0_msg, req1_msg, rsp_ack, core_done, core_dec,
      input  req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_key, core_msg
   );
endinterface

// File: rtl/aes_rr_pick.sv
// Combinational two-way round-robin picker.
//   valid     : request bits of port 0 and port 1
//   last      : port granted most recently
//   grant_vld : at least one port is requesting
//   grant_idx : chosen port; on a tie the port other than last wins
module aes_rr_pick (
   input  logic [1:0] valid,
   input  logic       last,
   output logic       grant_vld,
   output logic       grant_idx
);

   always_comb begin
      grant_vld = |valid;
      if (valid == 2'b11) begin
         grant_idx = ~last;
      end else begin
         grant_idx = valid[1];
      end
   end

endmodule

// File: rtl/aes_arbiter.sv
// Two-port arbiter in front of a single AES-128 decryption core.
//   CLK, RESET : clock and synchronous active-high reset
//   bus        : aes_arbiter_if.slave (request ports, response ports, core control)
// One transaction at a time: IDLE grants a port and latches its key/ciphertext, RUN holds
// core_start with a watchdog, DRAIN waits for core_done to fall, RESP holds the result
// until the granted port acknowledges it.
module aes_arbiter
   import aes_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 200
) (
   input logic          CLK,
   input logic          RESET,
   aes_arbiter_if.slave bus
);

   localparam logic [WDOG_W-1:0] TIMEOUT_CNT = WDOG_W'(TIMEOUT);

   arb_state_t        state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              last_q, last_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic [127:0]      key_q, key_d;
   logic [127:0]      msg_q, msg_d;
   logic [127:0]      res_q, res_d;
   logic              err_q, err_d;

   logic              pick_vld;
   logic              pick_idx;
   logic [WDOG_W-1:0] wdog_inc;

   aes_rr_pick u_pick (
      .valid     (bus.req_valid),
      .last      (last_q),
      .grant_vld (pick_vld),
      .grant_idx (pick_idx)
   );

   assign wdog_inc = wdog_q + 1'b1;

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;  // port 0 wins the first tie
         wdog_q  <= '0;
         key_q   <= '0;
         msg_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
         key_q   <= key_d;
         msg_q   <= msg_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      wdog_d  = wdog_q;
      key_d   = key_q;
      msg_d   = msg_q;
      res_d   = res_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gnt_d   = pick_idx;
               last_d  = pick_idx;
               key_d   = pick_idx ? bus.req1_key : bus.req0_key;
               msg_d   = pick_idx ? bus.req1_msg : bus.req0_msg;
               wdog_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            wdog_d = wdog_inc;
            // done beats a coincident timeout
            if (bus.core_done) begin
               res_d   = bus.core_dec;
               err_d   = 1'b0;
               state_d = DRAIN;
            end else if (wdog_inc == TIMEOUT_CNT) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!bus.core_done) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ack[gnt_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.req_ready  = 2'b00;
      bus.core_start = 1'b0;
      bus.rsp_valid  = 2'b00;
      bus.rsp_data   = '0;
      bus.rsp_err    = 1'b0;
      bus.core_key   = key_q;
      bus.core_msg   = msg_q;
      unique case (state_q)
         IDLE: begin
            // no accept pulse while in reset, since the grant would be discarded
            if (pick_vld && !RESET) begin
               bus.req_ready = port_onehot(pick_idx);
            end
         end
         RUN: bus.core_start = 1'b1;
         DRAIN: ;
         RESP: begin
            bus.rsp_valid = port_onehot(gnt_q);
            bus.rsp_data  = res_q;
            bus.rsp_err   = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_aes_arbiter.sv
module tb_aes_arbiter;

   localparam int unsigned TO = 20;

   localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

   typedef struct {
      int           port;
      logic [127:0] data;
      logic         err;
   } exp_t;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   aes_arbiter_if bus ();

   aes_arbiter #(.TIMEOUT(TO)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int   n_cmp = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // ---------------- request side ----------------
   int         issued[2] = '{0, 0};
   int         taken[2] = '{0, 0};
   logic [1:0] take_pend = 2'b00;

   assign bus.req_valid = {issued[1] != taken[1], issued[0] != taken[0]};
   assign bus.req0_key  = KEY_A;
   assign bus.req0_msg  = CT_A;
   assign bus.req1_key  = KEY_B;
   assign bus.req1_msg  = CT_B;

   // Accept seen now completes at the next posedge; retire it one negedge later.
   always @(negedge CLK) begin
      if (bus.req_ready != 2'b00) begin
         check("req_ready_onehot", 128'($onehot(bus.req_ready)), 128'd1);
         check("req_ready_without_valid", 128'(bus.req_ready & ~bus.req_valid), 128'd0);
      end
      for (int i = 0; i < 2; i++) begin
         if (take_pend[i]) taken[i] <= taken[i] + 1;
      end
      take_pend <= bus.req_valid & bus.req_ready;
   end

   // ---------------- core model ----------------
   int core_lat = 3;
   bit core_hang = 1'b0;
   int core_cnt = 0;

   function automatic logic [127:0] core_dec_f(logic [127:0] k, logic [127:0] m);
      if (k == KEY_A && m == CT_A) return PT_A;
      if (k == KEY_B && m == CT_B) return PT_B;
      return {128{1'b1}};
   endfunction

   always @(posedge CLK) core_cnt <= bus.core_start ? core_cnt + 1 : 0;
   assign bus.core_done = bus.core_start && !core_hang && (core_cnt >= core_lat);
   assign bus.core_dec  = core_dec_f(bus.core_key, bus.core_msg);

   // ---------------- response monitor (scoreboard) ----------------
   logic [1:0] prev_rv = 2'b00;

   always @(negedge CLK) begin : monitor
      exp_t e;
      if (bus.rsp_valid != 2'b00 && prev_rv == 2'b00) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: rsp_valid=%b, want no response", bus.rsp_valid);
         end else begin
            e = exp_q.pop_front();
            check("rsp_port", 128'(bus.rsp_valid), (e.port == 0) ? 128'd1 : 128'd2);
            check("rsp_data", bus.rsp_data, e.data);
            check("rsp_err", 128'(bus.rsp_err), 128'(e.err));
         end
      end
      prev_rv <= bus.rsp_valid;
   end

   // ---------------- ack driver ----------------
   int           ack_delay = 0;
   int           ack_wait = 0;
   bit           acked = 1'b0;
   logic [1:0]   held_v = 2'b00;
   logic [127:0] held_d = '0;

   initial bus.rsp_ack = 2'b00;

   always @(negedge CLK) begin
      if (acked) begin
         check("rsp_valid_clear", 128'(bus.rsp_valid), 128'd0);
         check("rsp_data_clear", bus.rsp_data, 128'd0);
      end
      acked <= 1'b0;
      if (bus.rsp_valid != 2'b00) begin
         if (ack_wait == 0) begin
            held_v <= bus.rsp_valid;
            held_d <= bus.rsp_data;
         end else begin
            check("hold_rsp_valid", 128'(bus.rsp_valid), 128'(held_v));
            check("hold_rsp_data", bus.rsp_data, held_d);
            check("hold_no_grant", 128'(bus.req_ready), 128'd0);
         end
         if (ack_wait < ack_delay) begin
            ack_wait    <= ack_wait + 1;
            bus.rsp_ack <= ~bus.rsp_valid;  // wrong-port ack must be ignored
         end else begin
            ack_wait    <= 0;
            bus.rsp_ack <= bus.rsp_valid;
            acked       <= 1'b1;
         end
      end else begin
         ack_wait    <= 0;
         // with delayed acks, also ack outside RESP; it must be ignored
         bus.rsp_ack <= (ack_delay > 0) ? 2'b11 : 2'b00;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic issue(int port, logic [127:0] data, logic err, bit expect_rsp);
      issued[port]++;
      if (expect_rsp) exp_q.push_back('{port: port, data: data, err: err});
   endtask

   task automatic wait_done(string name);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && bus.rsp_valid == 2'b00 && bus.req_valid == 2'b00 &&
               !bus.core_start) && n < 2000) begin
         step();
         n++;
      end
      if (n >= 2000) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_wait: still busy after %0d cycles, want idle", name, n);
      end
   endtask

   task automatic wait_start(string name, output bit ok);
      int n;
      n = 0;
      while (!bus.core_start && n < 200) begin
         step();
         n++;
      end
      ok = bus.core_start;
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_start: core_start=0 after %0d cycles, want 1", name, n);
      end
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_req_ready"}, 128'(bus.req_ready), 128'd0);
      check({tag, "_core_start"}, 128'(bus.core_start), 128'd0);
      check({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'd0);
      check({tag, "_rsp_err"}, 128'(bus.rsp_err), 128'd0);
      check({tag, "_rsp_data"}, bus.rsp_data, 128'd0);
      check({tag, "_core_key"}, bus.core_key, 128'd0);
      check({tag, "_core_msg"}, bus.core_msg, 128'd0);
   endtask

   initial begin
      bit ok;
      int cnt;

      step(2);
      check_all_zero("reset");
      RESET = 1'b0;
      step();

      // tie right after reset: port 0 first, then port 1
      issue(0, PT_A, 1'b0, 1'b1);
      issue(1, PT_B, 1'b0, 1'b1);
      wait_done("tie");

      // fairness: both held valid for four transactions -> 0,1,0,1
      for (int k = 0; k < 2; k++) begin
         issue(0, PT_A, 1'b0, 1'b1);
         issue(1, PT_B, 1'b0, 1'b1);
      end
      wait_done("fair");

      // single requests on each port
      issue(0, PT_A, 1'b0, 1'b1);
      wait_done("single0");
      issue(1, PT_B, 1'b0, 1'b1);
      wait_done("single1");

      // delayed ack with a competing request pending
      ack_delay = 50;
      issue(0, PT_A, 1'b0, 1'b1);
      cnt = 0;
      while (bus.rsp_valid == 2'b00 && cnt < 200) begin
         step();
         cnt++;
      end
      issue(1, PT_B, 1'b0, 1'b1);
      wait_done("delay");
      ack_delay = 0;
      step(2);

      // timeout: core never finishes
      core_hang = 1'b1;
      issue(0, 128'd0, 1'b1, 1'b1);
      wait_start("timeout", ok);
      if (ok) begin
         cnt = 0;
         while (bus.core_start && cnt < 200) begin
            step();
            cnt++;
         end
         check("timeout_run_cycles", 128'(cnt), 128'(TO));
      end
      wait_done("timeout");
      core_hang = 1'b0;

      // reset 10 cycles into RUN: no response, next tie goes to port 0
      core_lat = 30;
      issue(0, PT_A, 1'b0, 1'b0);
      wait_start("rstrun", ok);
      step(10);
      RESET = 1'b1;
      step();
      check_all_zero("rstrun");
      RESET = 1'b0;
      core_lat = 3;
      step(40);
      issue(0, PT_A, 1'b0, 1'b1);
      issue(1, PT_B, 1'b0, 1'b1);
      wait_done("rsttie");
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
